// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM states, gap length, frame-length helper.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int GAP_CYCLES = 1;

    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/output_serializer_if.sv
// Word handshake plus serial link outputs; slave = serializer, master = source/observer.
interface output_serializer_if #(
    parameter int DATA_WIDTH = 25
);
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  data_accept;
    logic                  serial_out;
    logic                  serial_ready;
    logic                  busy;

    modport slave (
        input  data, data_valid,
        output data_accept, serial_out, serial_ready, busy
    );

    modport master (
        output data, data_valid,
        input  data_accept, serial_out, serial_ready, busy
    );
endinterface

// File: rtl/output_serializer.sv
// Parallel-to-serial transmitter, LSB first, one word in flight plus one buffered.
// Define OUTPUT_SERIALIZER_PARITY_EN to append an even-parity bit after the MSB.
module output_serializer
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = 25
) (
    input  logic                 fast_clk,
    input  logic                 reset,
    output_serializer_if.slave   link
);

`ifdef OUTPUT_SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int FRAME_LEN = frame_len(DATA_WIDTH, PARITY_EN);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]   shifter_q, shifter_d;
    logic [DATA_WIDTH-1:0]  buf_q, buf_d;
    logic                   full_q, full_d;
    logic                   accept_fire;

    function automatic logic [FRAME_LEN-1:0] frame_word(input logic [DATA_WIDTH-1:0] w);
`ifdef OUTPUT_SERIALIZER_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    assign accept_fire = link.data_valid && !full_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shifter_d = shifter_q;
        buf_d     = buf_q;
        full_d    = full_q;
        unique case (state_q)
            IDLE: begin
                if (accept_fire) begin
                    shifter_d = frame_word(link.data);
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shifter_d = shifter_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
                if (accept_fire) begin
                    buf_d  = link.data;
                    full_d = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q != GAP_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                    if (accept_fire) begin
                        buf_d  = link.data;
                        full_d = 1'b1;
                    end
                end else if (full_q) begin
                    // A buffered word always wins over a newly offered one.
                    shifter_d = frame_word(buf_q);
                    full_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end else if (accept_fire) begin
                    shifter_d = frame_word(link.data);
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge fast_clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
        end
    end

    // NOTE: datapath registers carry no reset; their contents are qualified by state_q/full_q.
    always_ff @(posedge fast_clk) begin
        shifter_q <= shifter_d;
        buf_q     <= buf_d;
    end

    assign link.data_accept  = !full_q;
    assign link.serial_ready = (state_q == SHIFT);
    assign link.serial_out   = (state_q == SHIFT) ? shifter_q[0] : 1'b0;
    assign link.busy         = (state_q != IDLE) || full_q;

endmodule

// File: tb/tb_output_serializer.sv
// Scoreboard bench for output_serializer: driver queues expected words, a monitor deserializes and compares.
// Honours OUTPUT_SERIALIZER_PARITY_EN to match the RTL build.
module tb_output_serializer;

    localparam int W = 25;
`ifdef OUTPUT_SERIALIZER_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic fast_clk = 1'b0;
    logic reset    = 1'b0;
    int   cyc      = 0;

    output_serializer_if #(.DATA_WIDTH(W)) link ();

    output_serializer #(.DATA_WIDTH(W)) dut (
        .fast_clk (fast_clk),
        .reset    (reset),
        .link     (link)
    );

    always #5 fast_clk = ~fast_clk;
    always @(posedge fast_clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           starts[$];
    logic [63:0]  acc;
    int           nbits       = 0;
    bit           in_frame    = 1'b0;
    int           frames_done = 0;
    int           ready_cycles = 0;
    logic         last_bit    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: collects each frame while serial_ready is high, scores it on the gap cycle.
    always @(negedge fast_clk) begin
        if (!reset) begin
            in_frame = 1'b0;
            nbits    = 0;
        end else if (link.serial_ready) begin
            ready_cycles++;
            if (!in_frame) begin
                in_frame = 1'b1;
                nbits    = 0;
                acc      = '0;
                starts.push_back(cyc);
            end
            if (nbits < 64) acc[nbits] = link.serial_out;
            nbits++;
        end else if (in_frame) begin
            logic [W-1:0] exp_w;
            in_frame = 1'b0;
            frames_done++;
            last_bit = (nbits > 0 && nbits <= 64) ? acc[nbits-1] : 1'b0;
            check("frame_len", 64'(nbits), 64'(L));
            check("gap_serial_out", 64'(link.serial_out), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 64'(acc[W-1:0]), 64'd0);
                check("unexpected_frame_present", 64'd1, 64'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check("frame_word", 64'(acc[W-1:0]), 64'(exp_w));
`ifdef OUTPUT_SERIALIZER_PARITY_EN
                check("frame_parity", 64'(acc[W]), 64'(^exp_w));
`endif
            end
        end
    end

    // Offer a word starting at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] w, output int waited);
        waited = 0;
        link.data       = w;
        link.data_valid = 1'b1;
        while (!link.data_accept && waited < 200) begin
            @(negedge fast_clk);
            waited++;
        end
        if (!link.data_accept) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            exp_q.push_back(w);
            @(negedge fast_clk);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || link.busy || in_frame) && n < 500) begin
            @(negedge fast_clk);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size() == 0 && !link.busy), 64'd1);
    endtask

    initial begin
        int wt;
        int base_frames;
        int base_ready;
        link.data       = '0;
        link.data_valid = 1'b0;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge fast_clk);
        check("rst_serial_out",   64'(link.serial_out),   64'd0);
        check("rst_serial_ready", 64'(link.serial_ready), 64'd0);
        check("rst_busy",         64'(link.busy),         64'd0);
        check("rst_data_accept",  64'(link.data_accept),  64'd1);
        reset = 1'b1;
        @(negedge fast_clk);

        // Single word 5: bit 0 appears the cycle after acceptance
        send(25'h0000005, wt);
        link.data_valid = 1'b0;
        check("t1_latency_ready", 64'(link.serial_ready), 64'd1);
        check("t1_latency_bit0",  64'(link.serial_out),   64'd1);
        drain("t1");
        check("t1_idle_busy", 64'(link.busy), 64'd0);

        // Two words on consecutive cycles
        starts.delete();
        send(25'h1FFFFFF, wt);
        send(25'h0000001, wt);
        link.data_valid = 1'b0;
        check("t2_accept_low", 64'(link.data_accept), 64'd0);
        check("t2_busy", 64'(link.busy), 64'd1);
        drain("t2");
        check("t2_frames", 64'(starts.size()), 64'd2);
        if (starts.size() >= 2)
            check("t2_spacing", 64'(starts[1] - starts[0]), 64'(L + 1));

        // Three words offered continuously: third waits for the first gap to end
        starts.delete();
        send(25'h0ABCDEF, wt);
        send(25'h1234567, wt);
        send(25'h0F0F0F0, wt);
        link.data_valid = 1'b0;
        check("t3_third_wait", 64'(wt), 64'(L));
        drain("t3");
        check("t3_frames", 64'(starts.size()), 64'd3);
        if (starts.size() >= 3) begin
            check("t3_spacing_a", 64'(starts[1] - starts[0]), 64'(L + 1));
            check("t3_spacing_b", 64'(starts[2] - starts[1]), 64'(L + 1));
        end

        // Reset at bit 10 of a frame with a buffered word
        send(25'h1555555, wt);
        send(25'h0AAAAAA, wt);
        link.data_valid = 1'b0;
        repeat (10) @(negedge fast_clk);
        check("t4_mid_frame", 64'(link.serial_ready), 64'd1);
        reset = 1'b0;
        exp_q.delete();
        @(negedge fast_clk);
        check("t4_rst_ready",  64'(link.serial_ready), 64'd0);
        check("t4_rst_busy",   64'(link.busy),         64'd0);
        check("t4_rst_accept", 64'(link.data_accept), 64'd1);
        reset = 1'b1;
        base_frames = frames_done;
        base_ready  = ready_cycles;
        repeat (60) @(negedge fast_clk);
        check("t4_no_frames", 64'(frames_done - base_frames), 64'd0);
        check("t4_no_ready",  64'(ready_cycles - base_ready), 64'd0);

`ifdef OUTPUT_SERIALIZER_PARITY_EN
        // Parity bit: 7 has odd weight, 3 even
        send(25'h0000007, wt);
        link.data_valid = 1'b0;
        drain("t5a");
        check("t5_parity_7", 64'(last_bit), 64'd1);
        send(25'h0000003, wt);
        link.data_valid = 1'b0;
        drain("t5b");
        check("t5_parity_3", 64'(last_bit), 64'd0);
`endif

        // 1000 random words, continuously offered
        base_frames = frames_done;
        for (int i = 0; i < 1000; i++) begin
            send(W'($urandom), wt);
        end
        link.data_valid = 1'b0;
        drain("t6");
        check("t6_frame_count", 64'(frames_done - base_frames), 64'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_serializer.md
# output_serializer

Parallel-to-serial transmitter, the transmit-side counterpart of the serial input collectors. It takes a parallel word through a valid/accept handshake and shifts it out LSB first on one serial data line, framed by a serial ready strobe, in the serial framing the collectors deserialize. It runs on the serial clock, holds one word in flight plus one buffered word, and instantiates once per serial link.

## Interface
- DATA_WIDTH, 25, word width in bits; ≥2 (25 = request word, 16 = memory response word)
- fast_clk  in  1  serial clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- data  in  DATA_WIDTH  parallel word to send
- data_valid  in  1  data holds a word to send
- data_accept  out  1  word accepted on an edge where data_valid && data_accept
- serial_out  out  1  serial data bit
- serial_ready  out  1  high for each cycle serial_out carries a frame bit
- busy  out  1  shifter active or holding buffer full

## Operation
- States: IDLE, SHIFT, GAP. Registers: shifter, bit counter ($clog2 of frame length), holding buffer plus full flag.
- Reset (reset==0 at an edge): state=IDLE, buffer empty, counter=0. Outputs: serial_out=0, serial_ready=0, busy=0, data_accept=1. Any in-flight or buffered word is discarded.
- data_accept = !buffer_full (registered state only, no combinational path from data_valid).
- Accept routing:
  - In IDLE or the final GAP cycle with the buffer empty, the accepted word loads straight into the shifter. State goes to SHIFT.
  - Otherwise the accepted word goes into the holding buffer.
- SHIFT:
  - serial_out = shifter[0] and serial_ready=1.
  - Each cycle shift right by one and increment the counter.
  - After the last frame bit, go to GAP.
- GAP:
  - Exactly one cycle with serial_ready=0 and serial_out=0, so the receiver sees a frame boundary.
  - Then, in priority order:
    - buffer full: move the buffer into the shifter, clear full, go to SHIFT.
    - else data_valid: take the word directly, go to SHIFT.
    - else: go to IDLE.
- Frame length: DATA_WIDTH bits, or DATA_WIDTH+1 with parity (see Configuration).
- busy = (state != IDLE) || buffer_full.
- Outside SHIFT, serial_out is driven 0.

## Timing
- Latency: word accepted at edge N from IDLE → bit 0 on serial_out in cycle N+1. serial_ready is high for cycles N+1 .. N+L, where L is the frame length. GAP is cycle N+L+1.
- Back-to-back throughput: one frame every L+1 cycles. The next frame's bit 0 appears in cycle N+L+2.
- Buffer full: data_accept drops the cycle after the buffering edge. It rises again the cycle after the buffer drains into the shifter at the end of GAP.
- Buffer loads while the shifter is also loading from data are impossible by construction (routing rule above).
- Reset mid-frame: serial_ready=0 from the cycle after the reset edge. No partial-frame completion.
- data_valid while data_accept=0: ignored. The source must hold data stable.

## Configuration
- OUTPUT_SERIALIZER_PARITY_EN defined:
  - An even-parity bit (XOR of the data bits) is sent after the MSB as frame bit DATA_WIDTH.
  - serial_ready is high for DATA_WIDTH+1 cycles.
  - Parity is computed at shifter load time.
- Undefined: the frame is DATA_WIDTH bits and no parity logic is built.
- The paired collector must use the matching setting.

## Structure
- Shared package serial_pkg:
  - state enum (IDLE, SHIFT, GAP)
  - GAP_CYCLES=1 constant
  - function for frame length given width and parity setting
- Single module. Shifter, counter and buffer are small enough that no sub-module is warranted.

## Test plan
- Reset, then DATA_WIDTH=25, data=25'h0000005 valid for 1 cycle → serial_ready high for exactly 25 cycles, serial_out = 1,0,1,0 then 21 zeros, then GAP, IDLE, busy=0.
- Two words 25'h1FFFFFF then 25'h0000001 on consecutive cycles → both accepted and data_accept low after the second. Frame 1 is all ones over cycles 1–25, gap at 26, frame 2 over cycles 27–51 with only bit 0 set.
- Three words offered continuously → the third waits with data_accept=0 until the end of the first GAP. Frames are separated by exactly one serial_ready-low cycle, with no word lost or duplicated.
- reset=0 asserted at bit 10 of a frame with a buffered word → next cycle serial_ready=0, busy=0, data_accept=1. The buffered word is never sent.
- With OUTPUT_SERIALIZER_PARITY_EN and data=25'h0000007 → 26 ready cycles, last bit 1. With data=25'h0000003 → last bit 0.
- Loopback to the matching collector with 1000 random words → collected words equal sent words, in order.
